data_ram_resp: RTL and testbench

Responder end of the data-memory interface driven by the MEM stage: accepts `dm_addr`/`dm_wen`/`dm_wdata` each cycle, performs byte-lane-masked writes into an on-chip word RAM, and returns `dm_rdata` one clock after the address (synchronous read, matching the MEM stage's two-cycle load handling). Because the asynchronous reset cannot clear a RAM array, an init sweep zeroes every word after reset before accesses are honoured. The block also provides a sticky out-of-range error flag and a one-cycle-latency debug read port for the board display.

---
 rtl/dram_pkg.sv | 12 +
 rtl/byte_lane_ram.sv | 52 +++++
 rtl/data_ram_resp.sv | 106 ++++++++++
 tb/tb_data_ram_resp.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and lane geometry for the data-memory responder.
package dram_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   localparam int LANES  = 4;
   localparam int LANE_W = 8;

endpackage

// File: rtl/byte_lane_ram.sv
// One byte lane of the data RAM: single write port, main and debug read ports,
// both read-first with registered outputs that reset to zero.
module byte_lane_ram
   import dram_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LANE_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [LANE_W-1:0] rd_data,
   output logic [LANE_W-1:0] dbg_data
);

   logic [LANE_W-1:0] mem [2**ADDR_W];

   logic [LANE_W-1:0] rd_data_q;
   logic [LANE_W-1:0] rd_data_d;
   logic [LANE_W-1:0] dbg_data_q;
   logic [LANE_W-1:0] dbg_data_d;

   // Reads sample the array before this edge's write lands, giving read-first.
   always_comb begin
      rd_data_d  = rd_en ? mem[rd_addr] : '0;
      dbg_data_d = mem[dbg_addr];
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         dbg_data_q <= '0;
      end else begin
         rd_data_q  <= rd_data_d;
         dbg_data_q <= dbg_data_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign dbg_data = dbg_data_q;

endmodule

// File: rtl/data_ram_resp.sv
// Data-memory responder: zeroing sweep after reset, then byte-masked writes,
// one-cycle reads, sticky out-of-range flag and a debug read port.
module data_ram_resp
   import dram_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [31:0]       dm_addr,
   input  logic [3:0]        dm_wen,
   input  logic [31:0]       dm_wdata,
   output logic [31:0]       dm_rdata,
   output logic              init_done,
   output logic              addr_err,
   input  logic              err_clr,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_rdata
);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] icnt_q;
   logic [ADDR_W-1:0] icnt_d;
   logic              init_done_q;
   logic              init_done_d;
   logic              addr_err_q;
   logic              addr_err_d;

   logic                      in_range;
   logic [ADDR_W-1:0]         widx;
   logic [ADDR_W-1:0]         wr_addr;
   logic [LANES-1:0]          wr_en;
   logic [LANES*LANE_W-1:0]   wr_data;
   logic                      rd_en;
   logic                      addr_lsb_unused;

   assign in_range        = (dm_addr[31:ADDR_W+2] == '0);
   assign widx            = dm_addr[ADDR_W+1:2];
   assign addr_lsb_unused = ^dm_addr[1:0];

   // The sweep owns the write port until every word is zeroed; requests are ignored.
   always_comb begin
      state_d     = state_q;
      icnt_d      = icnt_q;
      init_done_d = init_done_q;
      addr_err_d  = addr_err_q;
      wr_addr     = widx;
      wr_en       = '0;
      wr_data     = dm_wdata;
      rd_en       = 1'b0;
      if (state_q == INIT) begin
         wr_addr = icnt_q;
         wr_en   = '1;
         wr_data = '0;
         icnt_d  = icnt_q + 1'b1;
         if (&icnt_q) begin
            state_d     = RUN;
            init_done_d = 1'b1;
         end
      end else begin
         wr_en = in_range ? dm_wen : '0;
         rd_en = in_range;
         if (!in_range) begin
            addr_err_d = 1'b1;
         end else if (err_clr) begin
            addr_err_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= INIT;
         icnt_q      <= '0;
         init_done_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         icnt_q      <= icnt_d;
         init_done_q <= init_done_d;
         addr_err_q  <= addr_err_d;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      byte_lane_ram #(
         .ADDR_W (ADDR_W)
      ) u_lane (
         .clk      (clk),
         .rst_n    (resetn),
         .wr_en    (wr_en[l]),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data[l*LANE_W +: LANE_W]),
         .rd_en    (rd_en),
         .rd_addr  (widx),
         .dbg_addr (dbg_addr),
         .rd_data  (dm_rdata[l*LANE_W +: LANE_W]),
         .dbg_data (dbg_rdata[l*LANE_W +: LANE_W])
      );
   end

   assign init_done = init_done_q;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// Directed bench for data_ram_resp with a word-level reference model checked every cycle.
module tb_data_ram_resp;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk      = 1'b0;
   logic              resetn   = 1'b1;
   logic [31:0]       dm_addr  = '0;
   logic [3:0]        dm_wen   = '0;
   logic [31:0]       dm_wdata = '0;
   logic              err_clr  = 1'b0;
   logic [ADDR_W-1:0] dbg_addr = '0;
   logic [31:0]       dm_rdata;
   logic              init_done;
   logic              addr_err;
   logic [31:0]       dbg_rdata;

   int nVectors     = 0;
   int nMiscompares = 0;

   data_ram_resp #(
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .dm_addr   (dm_addr),
      .dm_wen    (dm_wen),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .init_done (init_done),
      .addr_err  (addr_err),
      .err_clr   (err_clr),
      .dbg_addr  (dbg_addr),
      .dbg_rdata (dbg_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wen,
                                input logic [31:0] wdata, input logic [ADDR_W-1:0] dbg,
                                input logic clr);
      dm_addr  = addr;
      dm_wen   = wen;
      dm_wdata = wdata;
      dbg_addr = dbg;
      err_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic waitInit(output int n);
      n = 0;
      while (!init_done && n < 1000) begin
         applyStimulus(32'h0, 4'h0, 32'h0, '0, 1'b0);
         n++;
      end
   endtask

   // Reference model: words tracked as plain integers, sweep as a cycle count since reset.
   int          icount = 0;
   logic [31:0] mmem [DEPTH];
   bit          known [DEPTH];
   logic [31:0] exp_rdata  = '0;
   logic [31:0] exp_dbg    = '0;
   bit          exp_rvalid = 1'b0;
   bit          exp_dvalid = 1'b0;
   bit          exp_done   = 1'b0;
   bit          exp_err    = 1'b0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         icount     = 0;
         exp_rdata  = '0;
         exp_dbg    = '0;
         exp_rvalid = 1'b1;
         exp_dvalid = 1'b1;
         exp_done   = 1'b0;
         exp_err    = 1'b0;
         for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      end else if (icount < DEPTH) begin
         exp_dvalid    = known[dbg_addr];
         exp_dbg       = mmem[dbg_addr];
         exp_rdata     = '0;
         exp_rvalid    = 1'b1;
         mmem[icount]  = '0;
         known[icount] = 1'b1;
         icount++;
         exp_done      = (icount == DEPTH);
      end else begin
         bit inr;
         int w;
         inr        = ((dm_addr >> (ADDR_W + 2)) == 0);
         w          = int'((dm_addr >> 2) % DEPTH);
         exp_rvalid = !inr || known[w];
         exp_rdata  = inr ? mmem[w] : 32'h0;
         exp_dvalid = known[dbg_addr];
         exp_dbg    = mmem[dbg_addr];
         if (inr) begin
            for (int l = 0; l < 4; l++) begin
               if (dm_wen[l]) mmem[w][8*l +: 8] = dm_wdata[8*l +: 8];
            end
         end
         if (!inr) exp_err = 1'b1;
         else if (err_clr) exp_err = 1'b0;
      end
   end

   always @(negedge clk) begin
      checkOutput("model_init_done", {31'b0, init_done}, {31'b0, exp_done});
      checkOutput("model_addr_err", {31'b0, addr_err}, {31'b0, exp_err});
      if (exp_rvalid) checkOutput("model_dm_rdata", dm_rdata, exp_rdata);
      if (exp_dvalid) checkOutput("model_dbg_rdata", dbg_rdata, exp_dbg);
   end

   initial begin
      int n;
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_init_done", {31'b0, init_done}, 32'h0);
      checkOutput("reset_addr_err", {31'b0, addr_err}, 32'h0);
      checkOutput("reset_dm_rdata", dm_rdata, 32'h0);
      checkOutput("reset_dbg_rdata", dbg_rdata, 32'h0);
      @(negedge clk);
      #1 resetn = 1'b1;

      // A store presented during the sweep at cycle 10 must be ignored.
      n = 0;
      while (!init_done && n < 1000) begin
         if (n == 9) applyStimulus(32'h40, 4'hF, 32'hCAFEF00D, 8'd5, 1'b0);
         else        applyStimulus(32'h0, 4'h0, 32'h0, 8'd5, 1'b0);
         n++;
         if (n == 10) checkOutput("init_write_rdata", dm_rdata, 32'h0);
      end
      checkOutput("init_cycles", n, 32'd256);

      applyStimulus(32'h0, 4'h0, 32'h0, 8'h77, 1'b0);
      checkOutput("dbg_after_init", dbg_rdata, 32'h0);
      applyStimulus(32'h40, 4'h0, 32'h0, 8'h10, 1'b0);
      checkOutput("init_write_dropped", dm_rdata, 32'h0);
      checkOutput("dbg_word16_zero", dbg_rdata, 32'h0);

      applyStimulus(32'h10, 4'hF, 32'hDEADBEEF, 8'h0, 1'b0);
      applyStimulus(32'h10, 4'b0100, 32'h00AA0000, 8'h0, 1'b0);
      applyStimulus(32'h10, 4'h0, 32'h0, 8'h04, 1'b0);
      checkOutput("lane_merge_rdata", dm_rdata, 32'hDEAABEEF);
      checkOutput("lane_merge_dbg", dbg_rdata, 32'hDEAABEEF);
      applyStimulus(32'h13, 4'b0001, 32'h00000011, 8'h04, 1'b0);
      checkOutput("partial_read_first", dm_rdata, 32'hDEAABEEF);
      checkOutput("dbg_read_first", dbg_rdata, 32'hDEAABEEF);
      applyStimulus(32'h10, 4'h0, 32'h0, 8'h04, 1'b0);
      checkOutput("partial_lane0", dm_rdata, 32'hDEAABE11);

      applyStimulus(32'h20, 4'hF, 32'h12345678, 8'h0, 1'b0);
      checkOutput("same_cycle_read_first", dm_rdata, 32'h0);
      applyStimulus(32'h20, 4'h0, 32'h0, 8'h08, 1'b0);
      checkOutput("reread_new_data", dm_rdata, 32'h12345678);
      checkOutput("dbg_new_data", dbg_rdata, 32'h12345678);

      applyStimulus(32'h0000_0400, 4'hF, 32'hFFFFFFFF, 8'h0, 1'b0);
      checkOutput("oor_write_err", {31'b0, addr_err}, 32'h1);
      checkOutput("oor_write_rdata", dm_rdata, 32'h0);
      applyStimulus(32'h0, 4'h0, 32'h0, 8'h0, 1'b0);
      checkOutput("word0_unchanged", dm_rdata, 32'h0);
      checkOutput("err_sticky", {31'b0, addr_err}, 32'h1);
      applyStimulus(32'h8000_0010, 4'h0, 32'h0, 8'h0, 1'b1);
      checkOutput("set_beats_clear", {31'b0, addr_err}, 32'h1);
      checkOutput("oor_read_zero", dm_rdata, 32'h0);
      applyStimulus(32'h0, 4'h0, 32'h0, 8'h0, 1'b1);
      checkOutput("err_cleared", {31'b0, addr_err}, 32'h0);

      applyStimulus(32'h80, 4'hF, 32'h55AA55AA, 8'h0, 1'b0);
      applyStimulus(32'h80, 4'h0, 32'h0, 8'h0, 1'b0);
      checkOutput("pre_reset_word", dm_rdata, 32'h55AA55AA);
      resetn = 1'b0;
      #1;
      checkOutput("async_reset_rdata", dm_rdata, 32'h0);
      checkOutput("async_reset_done", {31'b0, init_done}, 32'h0);
      @(negedge clk);
      #1 resetn = 1'b1;
      repeat (100) applyStimulus(32'h0, 4'h0, 32'h0, 8'h0, 1'b0);
      checkOutput("mid_init_not_done", {31'b0, init_done}, 32'h0);
      resetn = 1'b0;
      @(negedge clk);
      #1 resetn = 1'b1;
      waitInit(n);
      checkOutput("reinit_cycles", n, 32'd256);
      applyStimulus(32'h80, 4'h0, 32'h0, 8'h20, 1'b0);
      checkOutput("post_reset_word_zero", dm_rdata, 32'h0);
      checkOutput("post_reset_dbg_zero", dbg_rdata, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
